// File: rtl/vit_ctrl.sv
// Frame sequencer for a rate-1/2, K=3 hard-decision Viterbi decoder: symbol intake,
// survivor writes, traceback reads and forward-order replay. Optional VIT_CTRL_STATS_EN adds frame_cnt.
module vit_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int AW        = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_cx0,
  input  logic          in_cx1,
  output logic          bmu_cx0,
  output logic          bmu_cx1,
  output logic          acs_en,
  output logic          sm_we,
  output logic [AW-1:0] sm_waddr,
  output logic          tb_start,
  output logic          tb_en,
  output logic [AW-1:0] sm_raddr,
  input  logic          tb_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          busy,
  output logic          frame_done
`ifdef VIT_CTRL_STATS_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FL       = CW'(FRAME_LEN);
  localparam logic [CW-1:0] FL_M1    = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(FRAME_LEN - 3);

  typedef enum logic [1:0] {ACC, TB, OUT} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       s_q, t_q, i_q;
  logic [CW-1:0]       rd_addr;
  logic                accept, out_xfer, last_xfer;
  logic                bmu_cx0_p0, bmu_cx1_p0;
  logic                wr_vld_p0;
  logic [AW-1:0]       wr_addr_p0;
  logic                cap_vld_p0;
  logic [AW-1:0]       cap_addr_p0;
  logic [(1<<AW)-1:0]  buf_q;
  logic                done_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ACC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    tb_start  = 1'b0;
    tb_en     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = (s_q < FL);
        if (s_q == FL) state_d = TB;
      end
      TB: begin
        busy     = 1'b1;
        tb_start = (t_q == '0);
        tb_en    = (t_q != FL);
        if (t_q == FL) state_d = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && (i_q == OUT_LAST)) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign last_xfer = out_xfer & (i_q == OUT_LAST);
  assign rd_addr   = FL_M1 - t_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
      t_q <= '0;
      i_q <= '0;
    end else begin
      if (accept)                         s_q <= s_q + 1'b1;
      else if (state_q == ACC && s_q == FL) s_q <= '0;
      if (state_q == TB)                  t_q <= (t_q == FL) ? '0 : t_q + 1'b1;
      if (out_xfer)                       i_q <= last_xfer ? '0 : i_q + 1'b1;
    end
  end

  // p0: accepted pair registered toward the BMU, with its ACS/survivor write strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bmu_cx0_p0 <= 1'b0;
      bmu_cx1_p0 <= 1'b0;
      wr_vld_p0  <= 1'b0;
      wr_addr_p0 <= '0;
      cap_vld_p0 <= 1'b0;
      done_p0    <= 1'b0;
    end else begin
      wr_vld_p0  <= accept;
      cap_vld_p0 <= tb_en;
      done_p0    <= last_xfer;
      if (accept) begin
        bmu_cx0_p0 <= in_cx0;
        bmu_cx1_p0 <= in_cx1;
        wr_addr_p0 <= s_q[AW-1:0];
      end
    end
  end

  // p0: traceback bit arrives one cycle after its read; file it under that read address
  always_ff @(posedge clk) begin
    cap_addr_p0 <= rd_addr[AW-1:0];
    if (cap_vld_p0) buf_q[cap_addr_p0] <= tb_bit;
  end

  assign bmu_cx0    = bmu_cx0_p0;
  assign bmu_cx1    = bmu_cx1_p0;
  assign acs_en     = wr_vld_p0;
  assign sm_we      = wr_vld_p0;
  assign sm_waddr   = wr_addr_p0;
  assign sm_raddr   = tb_en ? rd_addr[AW-1:0] : '0;
  assign out_bit    = out_valid & buf_q[i_q[AW-1:0]];
  assign frame_done = done_p0;

`ifdef VIT_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          frame_cnt_q <= '0;
    else if (last_xfer) frame_cnt_q <= sat_inc(frame_cnt_q);
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vit_ctrl.sv
// Scoreboard bench for vit_ctrl: expected writes/bits queued at stimulus time, popped at DUT output.
module tb_vit_ctrl;
  localparam int FL   = 16;
  localparam int AW   = 4;
  localparam int NOUT = FL - 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_cx0 = 1'b0, in_cx1 = 1'b0;
  logic tb_bit = 1'b0, out_ready = 1'b0;
  logic in_ready, bmu_cx0, bmu_cx1, acs_en, sm_we, tb_start, tb_en;
  logic out_valid, out_bit, busy, frame_done;
  logic [AW-1:0] sm_waddr, sm_raddr;
`ifdef VIT_CTRL_STATS_EN
  logic [15:0] frame_cnt;
`endif

  vit_ctrl #(.FRAME_LEN(FL), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cx0(in_cx0), .in_cx1(in_cx1), .bmu_cx0(bmu_cx0), .bmu_cx1(bmu_cx1),
    .acs_en(acs_en), .sm_we(sm_we), .sm_waddr(sm_waddr), .tb_start(tb_start),
    .tb_en(tb_en), .sm_raddr(sm_raddr), .tb_bit(tb_bit), .out_valid(out_valid),
    .out_ready(out_ready), .out_bit(out_bit), .busy(busy), .frame_done(frame_done)
`ifdef VIT_CTRL_STATS_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [AW+1:0]  qw[$];
  logic           qo[$];
  logic [AW+1:0]  ew;
  logic           eo;
  logic [FL-1:0]  pat;
  int             rd_exp = FL - 1;
  bit             pend_v = 1'b0;
  logic [AW-1:0]  pend_a = '0;
  int             nw = 0, no = 0, ndone = 0, cyc = 0;
  bit             done_exp = 1'b0, prev_stall = 1'b0;
  logic           prev_bit = 1'b0;
  int             or_mode = 0;

  // survivor-memory model answers one cycle after each read; downstream ready pattern
  always @(posedge clk) begin
    #1;
    tb_bit    = pend_v ? pat[pend_a] : 1'b0;
    out_ready = (or_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      if (acs_en || sm_we) begin
        check("acs_eq_we", acs_en, sm_we);
        if (qw.size() == 0) check("spurious_write", 1, 0);
        else begin
          ew = qw.pop_front();
          check("waddr", sm_waddr, ew[AW+1:2]);
          check("bmu_cx", {bmu_cx1, bmu_cx0}, ew[1:0]);
        end
        nw++;
      end
      if (tb_start) begin
        check("tb_start_en", tb_en, 1);
        rd_exp = FL - 1;
      end
      if (tb_en) begin
        check("raddr", sm_raddr, rd_exp);
        rd_exp--;
      end
      pend_v = tb_en;
      pend_a = sm_raddr;
      if (in_ready) check("busy_acc", busy, 0);
      if (tb_en || out_valid) begin
        check("busy_run", busy, 1);
        check("in_ready_run", in_ready, 0);
      end
      if (out_valid && prev_stall) check("out_hold", out_bit, prev_bit);
      if (frame_done || done_exp) begin
        check("frame_done", frame_done, done_exp);
        if (frame_done) begin
          check("in_ready_after", in_ready, 1);
          check("n_writes", nw, FL);
          check("n_outs", no, NOUT);
          ndone++;
          nw = 0;
          no = 0;
        end
      end
      done_exp = 1'b0;
      if (out_valid && out_ready) begin
        if (qo.size() == 0) check("spurious_out", 1, 0);
        else begin
          eo = qo.pop_front();
          check("out_bit", out_bit, eo);
        end
        no++;
        if (no == NOUT) done_exp = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_bit   = out_bit;
    end
  end

  task automatic send_pair(input int k, input logic c0, input logic c1, input bit gap);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_cx0 = c0;
    in_cx1 = c1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) qw.push_back({k[AW-1:0], c1, c0});
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit gap, input logic [FL-1:0] p, input bit ones);
    pat = p;
    for (int a = 0; a < NOUT; a++) qo.push_back(p[a]);
    for (int k = 0; k < FL; k++) begin
      send_pair(k, ones ? 1'b1 : 1'($urandom_range(0, 1)), ones ? 1'b1 : 1'($urandom_range(0, 1)), gap);
      if (k == FL - 1 && !gap) check("in_ready_drop", in_ready, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n0, w;
    n0 = ndone;
    w = 0;
    while (ndone == n0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    check("frame_done_seen", ndone, n0 + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_tb();
    int w, n0;
    w = 0;
    send_frame(1'b0, 16'($urandom), 1'b0);
    do begin
      @(negedge clk);
      w++;
    end while (!(tb_en && sm_raddr == 4'd9) && w < 500);
    check("reach_raddr9", sm_raddr, 9);
    n0 = ndone;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tb_en", tb_en, 0);
    check("rst_done", frame_done, 0);
    qw.delete();
    qo.delete();
    nw = 0;
    no = 0;
    done_exp = 1'b0;
    prev_stall = 1'b0;
    pend_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_rst", ndone, n0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got hang expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_acs_en", acs_en, 0);
    check("idle_sm_we", sm_we, 0);
    check("idle_tb_en", tb_en, 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_waddr", sm_waddr, 0);
    @(posedge clk);
    #1;

    or_mode = 0;
    send_frame(1'b0, 16'b0010_1101_0011_1001, 1'b1);
    wait_done();

    or_mode = 1;
    send_frame(1'b1, 16'($urandom), 1'b0);
    wait_done();

    or_mode = 0;
    reset_mid_tb();
    send_frame(1'b0, 16'($urandom), 1'b0);
    wait_done();

`ifdef VIT_CTRL_STATS_EN
    send_frame(1'b1, 16'($urandom), 1'b0);
    wait_done();
    send_frame(1'b0, 16'($urandom), 1'b0);
    wait_done();
    check("frame_cnt_3", frame_cnt, 3);
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    send_frame(1'b0, 16'($urandom), 1'b0);
    wait_done();
    send_frame(1'b0, 16'($urandom), 1'b0);
    wait_done();
    check("frame_cnt_sat", frame_cnt, 16'hFFFF);
`endif

    check("qw_empty", qw.size(), 0);
    check("qo_empty", qo.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vit_ctrl.md
Name: vit_ctrl

Overview:
- Frame sequencer for the rate-1/2, K=3 hard-decision Viterbi decoder.
- Accepts received symbol pairs over a valid/ready handshake and feeds each pair to the branch metric unit.
- Issues one ACS/survivor-memory write per trellis step, then runs traceback over the survivor memory.
- Buffers the traced-back bits and replays them in forward order, with the 2 zero tail bits dropped.

Parameters:
- FRAME_LEN, 16: trellis steps per frame, including 2 tail steps; legal range 3..2**AW.
- AW, 4: survivor memory address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  symbol pair available.
- in_ready  out  1  controller accepts a symbol pair this cycle.
- in_cx0  in  1  received code bit 0.
- in_cx1  in  1  received code bit 1.
- bmu_cx0  out  1  registered code bit 0 to the BMU.
- bmu_cx1  out  1  registered code bit 1 to the BMU.
- acs_en  out  1  ACS update strobe, one per trellis step.
- sm_we  out  1  survivor memory write enable.
- sm_waddr  out  AW  survivor memory write address.
- tb_start  out  1  traceback begin pulse, start state 0.
- tb_en  out  1  traceback read strobe.
- sm_raddr  out  AW  survivor memory read address.
- tb_bit  in  1  decoded bit from traceback, valid 1 cycle after a tb_en cycle.
- out_valid  out  1  decoded bit available.
- out_ready  in  1  downstream accepts the decoded bit.
- out_bit  out  1  decoded data bit.
- busy  out  1  high in TB and OUT states.
- frame_done  out  1  1-cycle pulse after the last data bit transfers.

Behaviour:
- Reset, asynchronous and active-high:
  - State returns to ACC.
  - All counters go to 0.
  - All outputs go to 0, except in_ready, which is 1 in ACC.
  - Bit buffer contents are don't-care.
  - Reset mid-frame discards the frame; no frame_done is generated.
- ACC state (step counter s = 0..FRAME_LEN-1):
  - in_ready = 1 until the last symbol is accepted.
  - On in_valid & in_ready: bmu_cx0/bmu_cx1 <= in_cx0/in_cx1 and s increments.
  - bmu_cx0/bmu_cx1 hold their value between accepts.
  - The cycle after each accept: acs_en = sm_we = 1, sm_waddr = index of the accepted pair (0-based).
  - Accept-to-strobe latency is exactly 1 cycle. Gaps in in_valid produce gaps in the strobes, never extra strobes.
  - After accepting pair FRAME_LEN-1, in_ready drops in the same edge. The next cycle carries the final write and moves to TB.
- TB state:
  - First cycle: tb_start = 1.
  - tb_en = 1 for exactly FRAME_LEN consecutive cycles, with sm_raddr = FRAME_LEN-1 down to 0, one address per cycle.
  - tb_bit sampled in cycle k+1 is stored at buffer[sm_raddr of cycle k].
  - One capture cycle follows the last read (tb_en = 0), then the state moves to OUT.
  - Total TB duration is FRAME_LEN+1 cycles.
- OUT state (index i = 0..FRAME_LEN-3):
  - out_valid = 1 and out_bit = buffer[i].
  - out_bit stays stable while out_valid & !out_ready.
  - On out_valid & out_ready, i increments.
  - On the transfer with i = FRAME_LEN-3: out_valid drops next cycle, frame_done pulses for 1 cycle, the state returns to ACC with in_ready = 1, and s = i = 0.
- busy = 1 exactly in TB and OUT.
- in_ready = 0 throughout TB and OUT; in_valid is ignored there.
- All counters are AW+1 bits wide, so the comparison with FRAME_LEN never wraps.

Optional Feature:
- Macro: VIT_CTRL_STATS_EN.
- Defined:
  - Adds output port frame_cnt [15:0].
  - Increments in the same cycle frame_done pulses.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle, in_valid = 0 for 10 cycles -> in_ready = 1; acs_en, sm_we, tb_en, out_valid, busy all 0; sm_waddr = 0.
- FRAME_LEN = 16, 16 back-to-back pairs (in_cx0, in_cx1) = (1,1) -> acs_en/sm_we high 16 consecutive cycles, each 1 cycle after its accept, sm_waddr 0..15. in_ready low after the 16th accept. tb_start pulse, then sm_raddr 15..0 on 16 tb_en cycles.
- Drive tb_bit pattern 0,0,1,0,1,1,0,1,0,0,1,1,1,0,0,1 for raddr 15..0 (tb_bit for raddr a = a's bit), out_ready = 1 -> out_bit sequence equals tb_bit for addresses 0..13 (14 bits). frame_done pulses once; in_ready returns to 1 the following cycle.
- in_valid toggled 1/0 every cycle, out_ready asserted only every 3rd cycle -> exactly 16 write strobes with no duplicates, 14 output bits, out_bit held stable while stalled.
- Assert reset during TB (after raddr 9) -> next edge: ACC, in_ready = 1, busy = 0, no frame_done. A following full frame decodes correctly.
- With VIT_CTRL_STATS_EN defined, run 3 frames -> frame_cnt = 3; forced preload to 16'hFFFE plus 2 frames -> frame_cnt holds at 16'hFFFF.
